// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional even
// parity, then 1 or 2 stop bits. Every output comes straight from a flop, so
// out_tx has no combinational path from the inputs.
module uart_tx_serializer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int PARITY_EN   = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic [7:0] in_data,
   input  logic       in_data_valid,
   output logic       out_tx,
   output logic       out_busy,
   output logic       out_tx_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int BW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   // Reject configurations the bit timing cannot represent.
   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q,  baud_d;
   logic [2:0]    bit_q,   bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          tx_q,    tx_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   logic bit_end;
   assign bit_end = (baud_q == BAUD_LAST);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; an unassigned path in always_comb infers a latch.
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BW'(1);
      end

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            // The out_tx_done cycle still belongs to the finished frame, so a
            // request arriving in it is dropped just like one during busy.
            if (in_data_valid && !busy_q && !done_q) begin
               state_d  = START;
               shift_d  = in_data;
               parity_d = ^in_data;
               baud_d   = '0;
               bit_d    = '0;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[1];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = IDLE;
                  bit_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset; reset aborts any frame.
   always_ff @(posedge in_clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (in_rst) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign out_tx      = tx_q;
   assign out_busy    = busy_q;
   assign out_tx_done = done_q;

endmodule
